hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline control block that complements the forwarding logic: it handles the hazards forwarding cannot resolve, by stalling, bubbling or flushing. It detects load-use hazards between ID and EX, freezes the pipeline while a multi-cycle data-memory access in MEM waits for its acknowledge, and flushes wrong-path instructions on a taken branch in EX. It sits beside the ID/EX and EX/MEM pipeline registers and drives their hold and clear controls plus the PC hold.

## Interface
- TIMEOUT_CYCLES, 255: maximum MEM_WAIT cycles before declaring a memory error (1..65535).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1_Id  in  5  rs1 of the instruction in ID.
- rs2_Id  in  5  rs2 of the instruction in ID.
- usesRs2_Id  in  1  ID instruction actually reads rs2 (R-type, store, branch).
- rdEx  in  5  rd of the instruction in EX.
- memRead_Ex  in  1  EX instruction is a load.
- branchTaken_Ex  in  1  EX branch/jump resolved taken.
- memReq_Mem  in  1  MEM instruction accesses data memory this cycle.
- memAck  in  1  data memory completes the access in MEM.
- stall_If  out  1  hold PC.
- stall_Id  out  1  hold IF/ID.
- bubble_Ex  out  1  load NOP into ID/EX (all control bits zero).
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB; block register-file write.
- flush_Id  out  1  clear IF/ID.
- memWait  out  1  registered: FSM in MEM_WAIT.
- memError  out  1  registered sticky: an access timed out.

## Operation
- FSM states: RUN, MEM_WAIT. Registered `state` and a timeout counter of width $clog2(TIMEOUT_CYCLES+1).
- Load-use hazard (loadUse): memRead_Ex && rdEx!=0 && (rdEx==rs1_Id || (usesRs2_Id && rdEx==rs2_Id)).
- RUN:
  - If memReq_Mem && !memAck: freeze=stall_If=stall_Id=1 this cycle, counter<=1, next state MEM_WAIT.
  - Else if branchTaken_Ex: flush_Id=1 and bubble_Ex=1. No stall. Any loadUse is ignored.
  - Else if loadUse: stall_If=stall_Id=bubble_Ex=1 for exactly one cycle. The next cycle EX holds the bubble, so the condition clears on its own.
  - Else all outputs 0.
- MEM_WAIT:
  - freeze=stall_If=stall_Id=1.
  - Branch flush and load-use are suppressed. Inputs stay frozen, so a pending branchTaken_Ex or loadUse is acted on in the first RUN cycle after release.
  - memAck=1: this is the last frozen cycle, next state RUN, counter<=0.
  - memAck=0 && counter==TIMEOUT_CYCLES: next state RUN, memError<=1, freeze released.
  - Else counter<=counter+1.
- Priority: memory freeze > branch flush > load-use.
- memError stays 1 until reset.
- memReq_Mem && memAck in the same RUN cycle is a single-cycle access: no freeze.
- Reset asserted at any time, including mid-MEM_WAIT: state=RUN, counter=0, memError=0. Every output is forced to 0 while reset is high, independent of the other inputs.

## Timing
- loadUse, branch and the entry freeze are Mealy outputs: combinational from inputs, valid in the same cycle.
- In MEM_WAIT, outputs are a function of state and memAck.
- Freeze length for an access acked N cycles after memReq_Mem is N+1 cycles; N=0 means no freeze.
- Load-use costs exactly 1 cycle. A taken branch costs 2 squashed slots (ID and the EX bubble) in 1 cycle.
- memWait is asserted from the cycle after entry up to and including the ack cycle.
- memError rises on the clock edge following the cycle where counter==TIMEOUT_CYCLES with no ack.

## Configuration
- HAZARD_STATS_EN defined: adds outputs stallCount (32 bits), counting cycles with stall_If=1, and flushCount (32 bits), counting cycles with flush_Id=1. Both are registered, wrap at 2^32, and are cleared by reset.
- HAZARD_STATS_EN undefined: neither port nor the counters exist. All other behaviour is identical.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - REG_X0=5'd0;
  - the default TIMEOUT_CYCLES constant.
- One sub-module, mem_wait_timer: the timeout counter with load, increment and terminal-count output, instantiated once.
- Hazard detection and output decode stay in the top module.

## Test plan
- Load-use: rdEx=5, memRead_Ex=1, rs1_Id=5 -> stall_If=stall_Id=bubble_Ex=1 for one cycle. Same with rdEx=0 -> no stall.
- rs2 qualification: rdEx=7, memRead_Ex=1, rs2_Id=7 -> with usesRs2_Id=0 no stall; with usesRs2_Id=1, one-cycle stall.
- Memory wait: memReq_Mem=1, memAck rises 3 cycles later -> freeze high for 4 cycles, memWait high for cycles 2-4, back to RUN, memError=0.
- Timeout with TIMEOUT_CYCLES=4 and memAck held 0 -> freeze releases after the counter reaches 4; memError=1 and stays 1 until reset.
- Simultaneous events: branchTaken_Ex=1 with loadUse true -> flush_Id=bubble_Ex=1, stall_If=0. Branch asserted during MEM_WAIT -> no flush until the cycle after memAck, then flush_Id=1.
- Reset pulse mid-MEM_WAIT at counter=2 -> all outputs 0 immediately, state RUN; with HAZARD_STATS_EN, stallCount=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Purpose : shared definitions for the pipeline hazard/stall controller.
// Contents: FSM state encoding, the x0 register index, and the default
//           memory-access timeout.
// Ports   : none (package).

package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Purpose : bundles the hazard inputs from ID/EX/MEM and the pipeline
//           hold/clear controls returned to the pipeline registers.
// Ports   : rs1_Id, rs2_Id, usesRs2_Id, rdEx, memRead_Ex, branchTaken_Ex,
//           memReq_Mem, memAck                  (pipeline -> unit)
//           stall_If, stall_Id, bubble_Ex, freeze, flush_Id, memWait,
//           memError                            (unit -> pipeline)
//           stallCount, flushCount (32 b)       only when HAZARD_STATS_EN
//           is defined
// Modports: master = pipeline side, slave = hazard_stall_unit side.

interface hazard_stall_unit_if;

   logic [4:0] rs1_Id;
   logic [4:0] rs2_Id;
   logic       usesRs2_Id;
   logic [4:0] rdEx;
   logic       memRead_Ex;
   logic       branchTaken_Ex;
   logic       memReq_Mem;
   logic       memAck;

   logic       stall_If;
   logic       stall_Id;
   logic       bubble_Ex;
   logic       freeze;
   logic       flush_Id;
   logic       memWait;
   logic       memError;

`ifdef HAZARD_STATS_EN
   logic [31:0] stallCount;
   logic [31:0] flushCount;

   modport master (
      output rs1_Id, rs2_Id, usesRs2_Id, rdEx, memRead_Ex, branchTaken_Ex,
             memReq_Mem, memAck,
      input  stall_If, stall_Id, bubble_Ex, freeze, flush_Id, memWait,
             memError, stallCount, flushCount
   );

   modport slave (
      input  rs1_Id, rs2_Id, usesRs2_Id, rdEx, memRead_Ex, branchTaken_Ex,
             memReq_Mem, memAck,
      output stall_If, stall_Id, bubble_Ex, freeze, flush_Id, memWait,
             memError, stallCount, flushCount
   );
`else
   modport master (
      output rs1_Id, rs2_Id, usesRs2_Id, rdEx, memRead_Ex, branchTaken_Ex,
             memReq_Mem, memAck,
      input  stall_If, stall_Id, bubble_Ex, freeze, flush_Id, memWait,
             memError
   );

   modport slave (
      input  rs1_Id, rs2_Id, usesRs2_Id, rdEx, memRead_Ex, branchTaken_Ex,
             memReq_Mem, memAck,
      output stall_If, stall_Id, bubble_Ex, freeze, flush_Id, memWait,
             memError
   );
`endif

endinterface

// File: rtl/hazard_stall_unit_mem_wait_timer.sv
// Purpose : counts cycles spent waiting for a data-memory acknowledge.
// Ports   : clk, reset (async, active high)
//           load  - start a new wait, count <= 1
//           clear - count <= 0
//           incr  - count <= count + 1
//           tc    - count has reached MAX_COUNT

module mem_wait_timer #(
   parameter int unsigned MAX_COUNT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic clear,
   input  logic incr,
   output logic tc
);

   localparam int W = $clog2(MAX_COUNT + 1);
   localparam logic [W-1:0] TC_VAL = W'(MAX_COUNT);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= W'(1);
      end else if (incr) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/hazard_stall_unit.sv
// Purpose : resolves the hazards forwarding cannot: load-use stalls,
//           pipeline freeze while a multi-cycle data access waits for its
//           ack (with timeout), and wrong-path flush on a taken branch.
// Ports   : clk            pipeline clock, rising edge
//           reset          async, active high; forces every output to 0
//           hz (slave)     hazard inputs and stall/bubble/flush/freeze
//                          controls, see hazard_stall_unit_if
// Config  : HAZARD_STATS_EN adds stallCount / flushCount cycle counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal flow; Mealy decode of mem-entry, branch, load-use
// MEM_WAIT | data access outstanding; whole pipeline frozen until ack or
//          | timeout

module hazard_stall_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   hazard_stall_unit_if.slave hz
);

   state_t state;
   state_t state_nxt;

   logic load_use;
   logic timer_load;
   logic timer_clear;
   logic timer_incr;
   logic timer_tc;
   logic timeout;
   logic mem_error_q;

   logic stall_c;
   logic bubble_c;
   logic freeze_c;
   logic flush_c;

   assign load_use = hz.memRead_Ex && (hz.rdEx != REG_X0) &&
                     ((hz.rdEx == hz.rs1_Id) ||
                      (hz.usesRs2_Id && (hz.rdEx == hz.rs2_Id)));

   mem_wait_timer #(
      .MAX_COUNT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .clear (timer_clear),
      .incr  (timer_incr),
      .tc    (timer_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_error_q <= 1'b0;
      end else if (timeout) begin
         mem_error_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      stall_c     = 1'b0;
      bubble_c    = 1'b0;
      freeze_c    = 1'b0;
      flush_c     = 1'b0;
      timer_load  = 1'b0;
      timer_clear = 1'b0;
      timer_incr  = 1'b0;
      timeout     = 1'b0;

      case (state)
         RUN: begin
            if (hz.memReq_Mem && !hz.memAck) begin
               freeze_c   = 1'b1;
               stall_c    = 1'b1;
               timer_load = 1'b1;
               state_nxt  = MEM_WAIT;
            end else if (hz.branchTaken_Ex) begin
               flush_c  = 1'b1;
               bubble_c = 1'b1;
            end else if (load_use) begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
         end

         MEM_WAIT: begin
            // Branch/load-use inputs are frozen with the pipeline and get
            // acted on in the first RUN cycle after release.
            freeze_c = 1'b1;
            stall_c  = 1'b1;
            if (hz.memAck) begin
               timer_clear = 1'b1;
               state_nxt   = RUN;
            end else if (timer_tc) begin
               timer_clear = 1'b1;
               timeout     = 1'b1;
               state_nxt   = RUN;
            end else begin
               timer_incr = 1'b1;
            end
         end

         default: begin
            state_nxt = RUN;
         end
      endcase

      // Outputs must read 0 for the whole reset pulse, not just after an edge.
      if (reset) begin
         stall_c  = 1'b0;
         bubble_c = 1'b0;
         freeze_c = 1'b0;
         flush_c  = 1'b0;
      end
   end

   assign hz.stall_If  = stall_c;
   assign hz.stall_Id  = stall_c;
   assign hz.bubble_Ex = bubble_c;
   assign hz.freeze    = freeze_c;
   assign hz.flush_Id  = flush_c;
   assign hz.memWait   = (state == MEM_WAIT);
   assign hz.memError  = mem_error_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count_q;
   logic [31:0] flush_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         if (stall_c) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
         if (flush_c) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign hz.stallCount = stall_count_q;
   assign hz.flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with TIMEOUT_CYCLES = 4.
// A cycle-level reference model tracks the outstanding memory access as an
// age in cycles; every negedge the DUT outputs are compared to it, and the
// directed scenarios also pin a few hand-derived literal values.

module tb_hazard_stall_unit;

   localparam int T = 4;

   typedef struct packed {
      logic si;
      logic sd;
      logic be;
      logic fr;
      logic fl;
      logic mw;
      logic me;
   } outs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   hazard_stall_unit_if hz();

   hazard_stall_unit #(
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_age = 0;      // 0 = no access outstanding, else cycles waited so far
   bit m_err = 1'b0;
   logic [31:0] m_sc = '0;
   logic [31:0] m_fc = '0;

   outs_t s_out;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic bit lu_now();
      return hz.memRead_Ex && (hz.rdEx != 5'd0) &&
             ((hz.rdEx == hz.rs1_Id) || (hz.usesRs2_Id && (hz.rdEx == hz.rs2_Id)));
   endfunction

   function automatic outs_t expect_now();
      outs_t e;
      e = '0;
      if (reset) return e;
      e.mw = (m_age > 0);
      e.me = m_err;
      if ((m_age > 0) || (hz.memReq_Mem && !hz.memAck)) begin
         e.fr = 1'b1; e.si = 1'b1; e.sd = 1'b1;
      end else if (hz.branchTaken_Ex) begin
         e.fl = 1'b1; e.be = 1'b1;
      end else if (lu_now()) begin
         e.si = 1'b1; e.sd = 1'b1; e.be = 1'b1;
      end
      return e;
   endfunction

   always @(posedge clk or posedge reset) begin : model
      outs_t e;
      if (reset) begin
         m_age = 0;
         m_err = 1'b0;
         m_sc  = '0;
         m_fc  = '0;
      end else begin
         e = expect_now();
         if (e.si) m_sc = m_sc + 32'd1;
         if (e.fl) m_fc = m_fc + 32'd1;
         if (m_age > 0) begin
            if (hz.memAck) m_age = 0;
            else if (m_age == T) begin
               m_age = 0;
               m_err = 1'b1;
            end else m_age = m_age + 1;
         end else if (hz.memReq_Mem && !hz.memAck) begin
            m_age = 1;
         end
      end
   end

   always @(negedge clk) begin : compare
      outs_t e;
      e = expect_now();
      chk1("stall_If",  hz.stall_If,  e.si);
      chk1("stall_Id",  hz.stall_Id,  e.sd);
      chk1("bubble_Ex", hz.bubble_Ex, e.be);
      chk1("freeze",    hz.freeze,    e.fr);
      chk1("flush_Id",  hz.flush_Id,  e.fl);
      chk1("memWait",   hz.memWait,   e.mw);
      chk1("memError",  hz.memError,  e.me);
`ifdef HAZARD_STATS_EN
      chk32("stallCount", hz.stallCount, m_sc);
      chk32("flushCount", hz.flushCount, m_fc);
`endif
   end

   // One pipeline cycle: drive inputs just after the edge, sample at negedge.
   task automatic cyc(input int rs1, input int rs2, input int u2, input int rd,
                      input int mr, input int br, input int req, input int ack,
                      input int rst = 0);
      hz.rs1_Id         = 5'(rs1);
      hz.rs2_Id         = 5'(rs2);
      hz.usesRs2_Id     = (u2 != 0);
      hz.rdEx           = 5'(rd);
      hz.memRead_Ex     = (mr != 0);
      hz.branchTaken_Ex = (br != 0);
      hz.memReq_Mem     = (req != 0);
      hz.memAck         = (ack != 0);
      reset             = (rst != 0);
      @(negedge clk);
      s_out = '{si: hz.stall_If, sd: hz.stall_Id, be: hz.bubble_Ex, fr: hz.freeze,
                fl: hz.flush_Id, mw: hz.memWait, me: hz.memError};
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fz;
      int mwc;

      // reset
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk32("rst_outputs", 32'(s_out), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // load-use on rs1, then the bubble sits in EX
      cyc(5, 0, 0, 5, 1, 0, 0, 0);
      chk1("lu_rs1_stall",  s_out.si, 1'b1);
      chk1("lu_rs1_bubble", s_out.be, 1'b1);
      cyc(5, 0, 0, 0, 0, 0, 0, 0);
      chk1("lu_one_cycle", s_out.si, 1'b0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      chk1("lu_x0_nostall", s_out.si, 1'b0);

      // rs2 qualification
      cyc(0, 7, 0, 7, 1, 0, 0, 0);
      chk1("rs2_unused_nostall", s_out.si, 1'b0);
      cyc(0, 7, 1, 7, 1, 0, 0, 0);
      chk1("rs2_used_stall", s_out.si, 1'b1);

      // branch beats load-use
      cyc(5, 0, 0, 5, 1, 1, 0, 0);
      chk1("br_lu_flush",   s_out.fl, 1'b1);
      chk1("br_lu_bubble",  s_out.be, 1'b1);
      chk1("br_lu_nostall", s_out.si, 1'b0);

      // memory wait, ack 3 cycles after request
      fz = 0; mwc = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 0, 0, (i < 4) ? 1 : 0, (i == 3) ? 1 : 0);
         fz  += int'(s_out.fr);
         mwc += int'(s_out.mw);
      end
      chk32("mem_freeze_len",  32'(fz),  32'd4);
      chk32("mem_memwait_len", 32'(mwc), 32'd3);
      chk1("mem_no_error", s_out.me, 1'b0);

      // branch pending during MEM_WAIT
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 0);
      chk1("bw_no_flush_wait", s_out.fl, 1'b0);
      cyc(0, 0, 0, 0, 0, 1, 1, 1);
      chk1("bw_no_flush_ack", s_out.fl, 1'b0);
      chk1("bw_freeze_ack",   s_out.fr, 1'b1);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk1("bw_flush_after", s_out.fl, 1'b1);
      chk1("bw_released",    s_out.fr, 1'b0);

      // load-use pending during MEM_WAIT
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(5, 0, 0, 5, 1, 0, 1, 1);
      chk1("lw_bubble_suppressed", s_out.be, 1'b0);
      cyc(5, 0, 0, 5, 1, 0, 0, 0);
      chk1("lw_bubble_after", s_out.be, 1'b1);

      // single-cycle access
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      chk1("single_no_freeze", s_out.fr, 1'b0);

      // timeout with ack never arriving
      fz = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0, 0, 0, 0, (i < 5) ? 1 : 0, 0);
         fz += int'(s_out.fr);
      end
      chk32("to_freeze_len", 32'(fz), 32'd5);
      chk1("to_error_set", s_out.me, 1'b1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk1("to_error_sticky", s_out.me, 1'b1);

      // reset mid-MEM_WAIT at counter 2
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
      chk32("rst_mid_outputs", 32'(s_out), 32'd0);
`ifdef HAZARD_STATS_EN
      chk32("rst_mid_stallcount", hz.stallCount, 32'd0);
`endif
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk1("post_rst_run_flush", s_out.fl, 1'b1);
      chk1("post_rst_memwait",   s_out.mw, 1'b0);
      chk1("post_rst_error",     s_out.me, 1'b0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
